addsub_arbiter: RTL

- Sequences a single shared 8-bit ripple add/subtract datapath between two requesters (req0, req1), e.g. two datapath stages that each need occasional add/sub.
- Round-robin arbitration; latches the winner's operands; registers sum/carry/overflow; returns a one-cycle done pulse to the winner.
- Sits between requesting blocks and the adder, and is the only driver of the adder's operand and carry-in inputs.

---
 rtl/addsub_arbiter_pkg.sv | 23 ++
 rtl/addsub_core.sv | 37 +++
 rtl/addsub_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the add/sub arbiter and its ripple datapath.
package addsub_arbiter_pkg;

  localparam int WIDTH_DEF = 8;

  // Operation select as seen on op0/op1.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Round-robin pick between two requesters. With a tie the side that was
  // not served last wins; otherwise whoever is asking wins.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit ripple add/subtract. Subtract is A + ~B + 1, so the
// same full-adder chain serves both ops with B inverted and carry-in forced.
module addsub_core
  import addsub_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic             inv;
  logic [WIDTH-1:0] bx;

  assign inv = (op == OP_SUB);
  assign bx  = b ^ {WIDTH{inv}};

  // Ripple the carry through one full-adder cell per bit; tap the carry
  // entering the MSB so the controller can form signed overflow.
  always_comb begin
    logic carry;
    sum   = '0;
    c_msb = 1'b0;
    carry = inv;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ bx[i] ^ carry;
      if (i == WIDTH - 1) c_msb = carry;
      carry = (a[i] & bx[i]) | (carry & (a[i] ^ bx[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for a single shared add/sub datapath.
// IDLE grants and latches operands, EXEC registers the result, RESP pulses
// done to the winner, then back to IDLE.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             op1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ov_flag,
  output logic             busy,
  output logic             gnt_id
);

  localparam int NREQ = 2;

  // Requester ports gathered into packed per-requester arrays.
  logic [NREQ-1:0]            req_v;
  logic [NREQ-1:0]            op_v;
  logic [NREQ-1:0][WIDTH-1:0] a_v;
  logic [NREQ-1:0][WIDTH-1:0] b_v;

  assign req_v = {req1, req0};
  assign op_v  = {op1, op0};
  assign a_v   = {a1, a0};
  assign b_v   = {b1, b0};

  state_t           state, state_nxt;
  logic             last_q;
  logic             gnt_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic             op_q;
  logic             take;
  logic             win;
  logic [NREQ-1:0]  done_v;

  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             c_msb;

  assign win = rr_pick(req_v[0], req_v[1], last_q);

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a     (opa_q),
    .b     (opb_q),
    .op    (op_q),
    .sum   (sum),
    .cout  (c_out),
    .c_msb (c_msb)
  );

  // Next-state and Moore outputs; reqs are only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    busy      = 1'b0;
    done_v    = '0;
    case (state)
      S_IDLE: begin
        if (|req_v) begin
          take      = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        busy      = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        busy          = 1'b1;
        done_v[gnt_q] = 1'b1;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Grant bookkeeping and operand capture; later operand changes are ignored.
  // The pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
      gnt_q  <= 1'b0;
      opa_q  <= '0;
      opb_q  <= '0;
      op_q   <= OP_ADD;
    end else if (take) begin
      last_q <= win;
      gnt_q  <= win;
      opa_q  <= a_v[win];
      opb_q  <= b_v[win];
      op_q   <= op_v[win];
    end
  end

  // Result registers load only at the EXEC edge and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      result  <= '0;
      cout    <= 1'b0;
      ov_flag <= 1'b0;
    end else if (state == S_EXEC) begin
      result  <= sum;
      cout    <= c_out;
      ov_flag <= c_msb ^ c_out;
    end
  end

  assign done0  = done_v[0];
  assign done1  = done_v[1];
  assign gnt_id = gnt_q;

endmodule
